// File: rtl/clock_mode_ctrl_pkg.sv
// clock_mode_ctrl_pkg: mode state codes, blink masks, output bundle and mode-advance helper
package clock_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        ADJ_MIN  = 3'd1,
        ADJ_HOUR = 3'd2,
        ALM_MIN  = 3'd3,
        ALM_HOUR = 3'd4
    } mode_t;

    localparam logic [3:0] BLANK_MIN  = 4'b0011;
    localparam logic [3:0] BLANK_HOUR = 4'b1100;

    typedef struct packed {
        logic       adjust;
        logic       alarm_set;
        logic       min_hour;
        logic       alarm_disp;
        logic       alarm_en;
        logic [3:0] blank;
        logic [2:0] mode;
    } ctl_t;

    function automatic mode_t next_mode(input mode_t s);
        case (s)
            RUN:      return ADJ_MIN;
            ADJ_MIN:  return ADJ_HOUR;
            ADJ_HOUR: return ALM_MIN;
            ALM_MIN:  return ALM_HOUR;
            default:  return RUN;
        endcase
    endfunction

endpackage

// File: rtl/clock_mode_ctrl_if.sv
// clock_mode_ctrl_if: level controls from the mode sequencer to the adjust/alarm/display datapaths
interface clock_mode_ctrl_if;

    logic       clock_adjust;
    logic       clock_alarm_set;
    logic       min_hour_set;
    logic       alarm_adjust_disp;
    logic       clock_alarm_en;
    logic [3:0] digit_blank;
    logic [2:0] mode_state;

    modport master (
        output clock_adjust, clock_alarm_set, min_hour_set, alarm_adjust_disp,
        output clock_alarm_en, digit_blank, mode_state
    );

    modport slave (
        input clock_adjust, clock_alarm_set, min_hour_set, alarm_adjust_disp,
        input clock_alarm_en, digit_blank, mode_state
    );

endinterface

// File: rtl/clock_mode_ctrl_btn_debounce.sv
// clock_mode_ctrl_btn_debounce: 2-flop synchroniser, 1 kHz-sampled debounce, 1-cycle press pulse on accepted rising edge
module clock_mode_ctrl_btn_debounce #(
    parameter int DEB_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEB_MS + 1);

    logic          s1, s2, level;
    logic [CW-1:0] cnt;

    // Count consecutive samples that disagree with the accepted level; accept after DEB_MS of them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            if (tick) begin
                if (s2 == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_MS - 1)) begin
                    cnt   <= '0;
                    level <= s2;
                    press <= s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: button debounce, run/adjust/alarm-set FSM, edit blink; idle timeout when CLOCK_MODE_TIMEOUT_EN is defined
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int DEB_MS    = 20,
    parameter int BLINK_MS  = 250,
    parameter int TIMEOUT_S = 30
) (
    input  logic              clk_100m,
    input  logic              cr,
    input  logic              tick_1k,
    input  logic              tick_1hz,
    input  logic              btn_mode,
    input  logic              btn_sel,
    clock_mode_ctrl_if.master ctl
);

    localparam int BW = $clog2(BLINK_MS + 1);

    mode_t         state, state_nxt;
    logic          p_mode, p_sel, to, chg, wrap, phase, phase_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    ctl_t          out_q, out_nxt;

    clock_mode_ctrl_btn_debounce #(.DEB_MS(DEB_MS)) u_deb_mode (
        .clk   (clk_100m),
        .rst   (cr),
        .tick  (tick_1k),
        .raw   (btn_mode),
        .press (p_mode)
    );

    clock_mode_ctrl_btn_debounce #(.DEB_MS(DEB_MS)) u_deb_sel (
        .clk   (clk_100m),
        .rst   (cr),
        .tick  (tick_1k),
        .raw   (btn_sel),
        .press (p_sel)
    );

`ifdef CLOCK_MODE_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_S + 1);

    logic [IW-1:0] idle, idle_nxt;

    // Idle seconds spent in an edit state; any press (or being in RUN) restarts the count
    always_comb begin
        to       = state != RUN && tick_1hz && idle == IW'(TIMEOUT_S - 1);
        idle_nxt = (to || p_mode || p_sel || state == RUN) ? '0 : idle + IW'(tick_1hz);
    end

    // Idle counter register
    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) idle <= '0;
        else    idle <= idle_nxt;
    end
`else
    logic unused_timeout;

    assign to             = 1'b0;
    assign unused_timeout = tick_1hz ^ TIMEOUT_S[0];
`endif

    // FSM state and blink phase registers
    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) begin
            state     <= RUN;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            state     <= state_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
        end
    end

    // Next state (timeout beats MODE, MODE beats SEL); blink restarts on every state change
    always_comb begin
        state_nxt     = to ? RUN : p_mode ? next_mode(state) : state;
        chg           = state_nxt != state;
        wrap          = blink_cnt == BW'(BLINK_MS - 1);
        blink_cnt_nxt = chg ? '0 : !tick_1k ? blink_cnt : wrap ? '0 : blink_cnt + 1'b1;
        phase_nxt     = chg ? 1'b0 : (tick_1k && wrap) ? !phase : phase;
    end

    // Decode from the next state so the registered outputs track the state register
    always_comb begin
        out_nxt            = '0;
        out_nxt.adjust     = state_nxt == ADJ_MIN || state_nxt == ADJ_HOUR;
        out_nxt.alarm_set  = state_nxt == ALM_MIN || state_nxt == ALM_HOUR;
        out_nxt.alarm_disp = state_nxt == ALM_MIN || state_nxt == ALM_HOUR;
        out_nxt.min_hour   = state_nxt == ADJ_HOUR || state_nxt == ALM_HOUR;
        out_nxt.alarm_en   = (state == RUN && p_sel && !p_mode) ? !out_q.alarm_en : out_q.alarm_en;
        out_nxt.blank      = (state_nxt != RUN && phase_nxt) ? (out_nxt.min_hour ? BLANK_HOUR : BLANK_MIN) : 4'b0000;
        out_nxt.mode       = state_nxt;
    end

    // Output register; cleared asynchronously with the rest of the block
    always_ff @(posedge clk_100m or posedge cr) begin
        if (cr) out_q <= '0;
        else    out_q <= out_nxt;
    end

    assign ctl.clock_adjust      = out_q.adjust;
    assign ctl.clock_alarm_set   = out_q.alarm_set;
    assign ctl.min_hour_set      = out_q.min_hour;
    assign ctl.alarm_adjust_disp = out_q.alarm_disp;
    assign ctl.clock_alarm_en    = out_q.alarm_en;
    assign ctl.digit_blank       = out_q.blank;
    assign ctl.mode_state        = out_q.mode;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: directed bench for clock_mode_ctrl with a cycle-level behavioural model and literal spot checks
module tb_clock_mode_ctrl;

    localparam int DEB = 4;
    localparam int BLK = 5;
    localparam int TOS = 3;
    localparam int M   = (1 << DEB) - 1;

    logic clk = 1'b0;
    logic cr = 1'b1;
    logic tick_1k = 1'b0;
    logic tick_1hz = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_sel = 1'b0;

    int checks = 0;
    int errors = 0;

    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(.DEB_MS(DEB), .BLINK_MS(BLK), .TIMEOUT_S(TOS)) dut (
        .clk_100m (clk),
        .cr       (cr),
        .tick_1k  (tick_1k),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_sel  (btn_sel),
        .ctl      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode as an integer 0..4, blink as ticks since entering the state,
    // buttons as the last DEB samples; a press pulse takes effect one clock later.
    int m_st, m_tk, m_idle, nst, hm, hs, nm_s, ns_s;
    bit m_en, pm, ps, lm, ls, to_m;

    function automatic bit accept(input int h, input int n, input bit s, input bit l);
        return n >= DEB && (h & M) == (s ? M : 0) && s != l;
    endfunction

    always @(posedge clk or posedge cr) begin
        if (cr) begin
            m_st = 0; m_tk = 0; m_idle = 0; m_en = 0; pm = 0; ps = 0;
            lm = 0; ls = 0; hm = 0; hs = 0; nm_s = 0; ns_s = 0;
        end else begin
            to_m = 0;
`ifdef CLOCK_MODE_TIMEOUT_EN
            to_m = m_st != 0 && tick_1hz && m_idle == TOS - 1;
`endif
            nst = m_st;
            if (to_m) nst = 0;
            else if (pm) nst = (m_st + 1) % 5;
            else if (ps && m_st == 0) m_en = !m_en;
            m_idle = (to_m || pm || ps || m_st == 0) ? 0 : m_idle + (tick_1hz ? 1 : 0);
            m_tk = (nst != m_st) ? 0 : m_tk + (tick_1k ? 1 : 0);
            m_st = nst;
            pm = 0;
            ps = 0;
            if (tick_1k) begin
                hm = ((hm << 1) | int'(btn_mode)) & M;
                hs = ((hs << 1) | int'(btn_sel)) & M;
                nm_s++;
                ns_s++;
                if (accept(hm, nm_s, btn_mode, lm)) begin lm = btn_mode; pm = btn_mode; end
                if (accept(hs, ns_s, btn_sel, ls)) begin ls = btn_sel; ps = btn_sel; end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        chk("mode_state", 32'(bus.mode_state), m_st);
        chk("clock_adjust", 32'(bus.clock_adjust), (m_st == 1 || m_st == 2) ? 1 : 0);
        chk("clock_alarm_set", 32'(bus.clock_alarm_set), (m_st == 3 || m_st == 4) ? 1 : 0);
        chk("alarm_adjust_disp", 32'(bus.alarm_adjust_disp), (m_st == 3 || m_st == 4) ? 1 : 0);
        chk("min_hour_set", 32'(bus.min_hour_set), (m_st == 2 || m_st == 4) ? 1 : 0);
        chk("clock_alarm_en", 32'(bus.clock_alarm_en), m_en ? 1 : 0);
        chk("digit_blank", 32'(bus.digit_blank),
            (m_st != 0 && (m_tk / BLK) % 2 == 1) ? ((m_st == 2 || m_st == 4) ? 12 : 3) : 0);
    end

    task automatic step(input bit t1k, input bit t1h);
        @(posedge clk);
        #1;
        tick_1k = t1k;
        tick_1hz = t1h;
    endtask

    task automatic ms();
        repeat (6) step(0, 0);
        step(1, 0);
        step(0, 0);
    endtask

    task automatic sec();
        step(0, 1);
        step(0, 0);
    endtask

    task automatic press(input bit m, input bit s);
        btn_mode = m;
        btn_sel = s;
        repeat (DEB) ms();
        btn_mode = 0;
        btn_sel = 0;
        repeat (DEB) ms();
    endtask

    int exp_st [4] = '{2, 3, 4, 0};
    int exp_alm[4] = '{0, 1, 1, 0};
    int exp_hr [4] = '{1, 0, 1, 0};
    int exp_adj[4] = '{1, 0, 0, 0};

    initial begin
        repeat (3) @(posedge clk);
        #1 cr = 0;
        chk("rst_mode", 32'(bus.mode_state), 0);
        chk("rst_adjust", 32'(bus.clock_adjust), 0);
        chk("rst_alarm_en", 32'(bus.clock_alarm_en), 0);
        chk("rst_blank", 32'(bus.digit_blank), 0);

        // 1. bounce: three toggles over three ticks, then a steady hold
        btn_mode = 1; ms();
        btn_mode = 0; ms();
        btn_mode = 1; ms();
        chk("bounce_early_mode", 32'(bus.mode_state), 0);
        repeat (DEB) ms();
        btn_mode = 0;
        repeat (DEB) ms();
        chk("bounce_mode", 32'(bus.mode_state), 1);
        chk("bounce_adjust", 32'(bus.clock_adjust), 1);
        chk("bounce_min_hour", 32'(bus.min_hour_set), 0);

        // 2. walk the rest of the mode ring
        for (int i = 0; i < 4; i++) begin
            press(1, 0);
            chk("ring_mode", 32'(bus.mode_state), exp_st[i]);
            chk("ring_alarm_set", 32'(bus.clock_alarm_set), exp_alm[i]);
            chk("ring_disp", 32'(bus.alarm_adjust_disp), exp_alm[i]);
            chk("ring_min_hour", 32'(bus.min_hour_set), exp_hr[i]);
            chk("ring_adjust", 32'(bus.clock_adjust), exp_adj[i]);
        end

        // 3. alarm arm toggling, then MODE and SEL together
        press(0, 1); chk("arm_1", 32'(bus.clock_alarm_en), 1);
        press(0, 1); chk("arm_0", 32'(bus.clock_alarm_en), 0);
        press(0, 1); chk("arm_1b", 32'(bus.clock_alarm_en), 1);
        press(1, 1);
        chk("both_mode", 32'(bus.mode_state), 1);
        chk("both_alarm_en", 32'(bus.clock_alarm_en), 1);
        press(0, 1);
        chk("edit_sel_mode", 32'(bus.mode_state), 1);
        chk("edit_sel_alarm_en", 32'(bus.clock_alarm_en), 1);

        // 4. blink in ADJ_HOUR: four ticks already elapsed on entry
        press(1, 0);
        chk("blink_mode", 32'(bus.mode_state), 2);
        chk("blink_t4", 32'(bus.digit_blank), 0);
        ms();           chk("blink_t5", 32'(bus.digit_blank), 12);
        repeat (4) ms(); chk("blink_t9", 32'(bus.digit_blank), 12);
        ms();           chk("blink_t10", 32'(bus.digit_blank), 0);
        repeat (5) ms(); chk("blink_t15", 32'(bus.digit_blank), 12);
        repeat (3) press(1, 0);
        chk("run_mode", 32'(bus.mode_state), 0);
        repeat (12) ms();
        chk("run_blank", 32'(bus.digit_blank), 0);

        // 5. idle timeout
        repeat (3) press(1, 0);
        chk("to_enter", 32'(bus.mode_state), 3);
`ifdef CLOCK_MODE_TIMEOUT_EN
        sec(); sec();
        chk("to_hold", 32'(bus.mode_state), 3);
        sec();
        chk("to_mode", 32'(bus.mode_state), 0);
        chk("to_alarm_set", 32'(bus.clock_alarm_set), 0);
        chk("to_disp", 32'(bus.alarm_adjust_disp), 0);
        chk("to_adjust", 32'(bus.clock_adjust), 0);
        repeat (3) press(1, 0);
        sec(); sec();
        press(0, 1);
        sec(); sec();
        chk("to_sel_hold", 32'(bus.mode_state), 3);
        sec();
        chk("to_sel_mode", 32'(bus.mode_state), 0);
`else
        repeat (10) sec();
        chk("no_to_mode", 32'(bus.mode_state), 3);
        repeat (2) press(1, 0);
`endif

        // 6. asynchronous reset mid ALM_HOUR with the alarm armed
        repeat (4) press(1, 0);
        chk("pre_rst_mode", 32'(bus.mode_state), 4);
        chk("pre_rst_alarm_en", 32'(bus.clock_alarm_en), 1);
        @(posedge clk);
        #3 cr = 1;
        #1;
        chk("arst_mode", 32'(bus.mode_state), 0);
        chk("arst_alarm_en", 32'(bus.clock_alarm_en), 0);
        chk("arst_alarm_set", 32'(bus.clock_alarm_set), 0);
        chk("arst_min_hour", 32'(bus.min_hour_set), 0);
        chk("arst_disp", 32'(bus.alarm_adjust_disp), 0);
        @(posedge clk);
        #1 cr = 0;
        repeat (3) ms();
        chk("post_rst_mode", 32'(bus.mode_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
